// File: rtl/riscv_btb.sv
// riscv_btb: direct-mapped branch target buffer with 2-bit saturating
// direction counters, used beside the fetch PC register to pick the
// next fetch address.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (clears valid, counters -> 00)
//   f_pc         fetch PC (bits [1:0] ignored)
//   pred_taken   combinational: redirect fetch to pred_target
//   pred_target  combinational: stored target when predicted taken, else f_pc+4
//   upd_en       EX stage resolved a jal/branch this cycle
//   upd_pc       PC of the resolved instruction
//   upd_target   resolved taken target
//   upd_taken    resolved direction
//   upd_is_jal   resolved instruction is an unconditional jal
//   flush        invalidate all entries (wins over a simultaneous update)
module riscv_btb #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    localparam int unsigned IDX_W  = $clog2(ENTRIES),
    localparam int unsigned TAG_W  = XLEN - IDX_W - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] f_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_is_jal,
    input  logic            flush
);

    // Entry storage
    logic              r_valid  [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [XLEN-1:0]   r_target [ENTRIES];

    // Lookup side
    logic [IDX_W-1:0]  w_f_idx;
    logic [TAG_W-1:0]  w_f_tag;
    logic              w_f_hit;

    // Update side
    logic [IDX_W-1:0]  w_u_idx;
    logic [TAG_W-1:0]  w_u_tag;
    logic              w_u_hit;
    logic              w_u_go;
    logic              w_wr_ctr;
    logic              w_wr_data;
    logic [1:0]        w_ctr_nxt;

    // Byte-offset bits of the update PC carry no information
    logic              w_unused_upd_lsb;
    assign w_unused_upd_lsb = ^upd_pc[1:0];

    // Zero-latency lookup
    assign w_f_idx = f_pc[IDX_W+1:2];
    assign w_f_tag = f_pc[XLEN-1:IDX_W+2];
    assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

    always_comb begin
        pred_taken  = w_f_hit && r_ctr[w_f_idx][1];
        pred_target = f_pc + XLEN'(4);
        if (pred_taken) begin
            pred_target = r_target[w_f_idx];
        end
    end

    // Training decision; flush and reset suppress any update
    assign w_u_idx = upd_pc[IDX_W+1:2];
    assign w_u_tag = upd_pc[XLEN-1:IDX_W+2];
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_u_go  = upd_en && !flush && !rst;

    always_comb begin
        w_wr_ctr  = 1'b0;
        w_wr_data = 1'b0;
        w_ctr_nxt = r_ctr[w_u_idx];
        if (w_u_go) begin
            if (w_u_hit) begin
                w_wr_ctr  = 1'b1;
                w_wr_data = upd_taken;
                if (upd_is_jal) begin
                    w_ctr_nxt = 2'b11;
                end else if (upd_taken) begin
                    w_ctr_nxt = (r_ctr[w_u_idx] == 2'b11) ? 2'b11 : 2'(r_ctr[w_u_idx] + 2'd1);
                end else begin
                    w_ctr_nxt = (r_ctr[w_u_idx] == 2'b00) ? 2'b00 : 2'(r_ctr[w_u_idx] - 2'd1);
                end
            end else if (upd_taken) begin
                // Allocate or replace; a not-taken miss leaves any alias intact
                w_wr_ctr  = 1'b1;
                w_wr_data = 1'b1;
                w_ctr_nxt = upd_is_jal ? 2'b11 : 2'b10;
            end
        end
    end

    // Valid bits and counters (reset-cleared)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b00;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_wr_ctr) begin
            r_ctr[w_u_idx] <= w_ctr_nxt;
            if (w_wr_data) begin
                r_valid[w_u_idx] <= 1'b1;
            end
        end
    end

    // Tags and targets need no reset; valid gates their use
    always_ff @(posedge clk) begin
        if (w_wr_data) begin
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= upd_target;
        end
    end

endmodule
